// File: rtl/cvt_unpack.sv
// 48-to-32-bit width converter: re-emits 48-bit stream words as big-endian 32-bit
// words, closing each frame with a zero-padded, byte-enabled partial word when needed.
module cvt_unpack #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk_wr,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    logic [63:0] data_buf;
    logic [3:0]  fill;
    logic        last_pend;

    logic        partial;
    logic        out_fire;
    logic        in_fire;
    logic        last_pend_eff;
    logic [3:0]  fill_eff;

    logic [63:0] buf_next;
    logic [3:0]  fill_next;
    logic        last_pend_next;

    // Outputs are decoded from registers only; nothing from in_* reaches out_*.
    assign partial   = (fill == 4'd2);
    assign out_valid = (fill >= 4'd4) | (last_pend & partial);
    assign out_data  = partial ? {data_buf[63:48], PAD_BYTE, PAD_BYTE} : data_buf[63:32];
    assign out_keep  = partial ? 4'b1100 : 4'b1111;
    assign out_last  = last_pend & out_valid & (fill <= 4'd4);
    assign out_fire  = out_valid & out_ready;

    // Occupancy after this cycle's output, so input can be taken in the same cycle.
    assign fill_eff      = out_fire ? (partial ? 4'd0 : fill - 4'd4) : fill;
    assign last_pend_eff = last_pend & ~(out_fire & out_last);
    assign in_ready      = ~last_pend_eff & (fill_eff <= 4'd2);
    assign in_fire       = in_valid & in_ready;

    assign busy = (fill != 4'd0) | last_pend;

    always_comb begin
        // NOTE: every variable gets a full default before the conditional updates, so no latch is inferred.
        buf_next = out_fire ? {data_buf[31:0], 32'd0} : data_buf;
        if (in_fire) begin
            // fill_eff can only be 0 or 2 here; in_ready guarantees it.
            if (fill_eff == 4'd0) begin
                buf_next[63:16] = in_data;
            end else begin
                buf_next[47:0] = in_data;
            end
        end
        fill_next      = fill_eff + (in_fire ? 4'd6 : 4'd0);
        // A new frame end may be accepted in the same cycle the previous one flushes.
        last_pend_next = last_pend_eff | (in_fire & in_last);
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            // NOTE: the byte buffer is reset too, so out_data reads zero while idle after reset.
            data_buf  <= 64'd0;
            fill      <= 4'd0;
            last_pend <= 1'b0;
            frame_cnt <= '0;
        end else begin
            data_buf  <= buf_next;
            fill      <= fill_next;
            last_pend <= last_pend_next;
            if (out_fire && out_last) begin
                frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cvt_unpack.sv
// Directed and randomized-backpressure bench for cvt_unpack; each scenario task checks
// its own results against hand-computed or bench-modelled values.
module tb_cvt_unpack;

    localparam logic [7:0] PAD = 8'h00;

    logic        clk_wr = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [48:0] in_q[$];      // {last, data}
    logic [36:0] got[$];       // {last, keep, data}
    logic [36:0] exp_q[$];
    int          got_cyc[$];
    bit          rdy_log[$];
    int          stall_err;
    bit          timed_out;

    always #5 clk_wr = ~clk_wr;

    cvt_unpack #(.PAD_BYTE(PAD), .CNT_W(16)) dut (
        .clk_wr    (clk_wr),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    // Streams in_q into the DUT and collects exp_outs output beats; entered and left 1 ns after a rising edge.
    task automatic run_stream(input int exp_outs, input int ready_pct, input int budget);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_data = '0;
        logic [3:0]  held_keep = '0;
        got.delete();
        got_cyc.delete();
        rdy_log.delete();
        stall_err = 0;
        timed_out = 1'b0;
        while (in_q.size() > 0 || got.size() < exp_outs) begin
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            in_valid = (in_q.size() > 0);
            if (in_valid) begin
                in_data = in_q[0][47:0];
                in_last = in_q[0][48];
            end
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk_wr);
            if (stalled && (!out_valid || out_data !== held_data || out_keep !== held_keep))
                stall_err++;
            if (in_valid) rdy_log.push_back(in_ready);
            if (out_valid && out_ready) begin
                got.push_back({out_last, out_keep, out_data});
                got_cyc.push_back(cyc);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_keep = out_keep;
            if (in_valid && in_ready) void'(in_q.pop_front());
            @(posedge clk_wr);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_last, out_keep, out_data, in_ready, busy, frame_cnt} !==
            {1'b0, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_values: got valid=%b last=%b keep=%b data=%h rdy=%b busy=%b cnt=%0d, want 0 0 1111 00000000 1 0 0",
                     out_valid, out_last, out_keep, out_data, in_ready, busy, frame_cnt);
        end
        rst = 1'b0;
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_one_word();
        in_q.push_back({1'b1, 48'hAABBCCDDEEFF});
        run_stream(2, 100, 50);
        checks++;
        if (got.size() != 2 || timed_out) begin
            errors++;
            $display("FAIL one_word_count: got %0d beats (timeout=%0b), want 2", got.size(), timed_out);
        end
        checks++;
        if (got[0] !== {1'b0, 4'b1111, 32'hAABBCCDD}) begin
            errors++;
            $display("FAIL one_word_beat0: got %h, want %h", got[0], {1'b0, 4'b1111, 32'hAABBCCDD});
        end
        checks++;
        if (got[1] !== {1'b1, 4'b1100, 32'hEEFF0000}) begin
            errors++;
            $display("FAIL one_word_beat1: got %h, want %h", got[1], {1'b1, 4'b1100, 32'hEEFF0000});
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL one_word_frame_cnt: got %0d, want 1", frame_cnt);
        end
    endtask

    task automatic test_two_word();
        logic [36:0] want[3];
        want[0] = {1'b0, 4'b1111, 32'h00112233};
        want[1] = {1'b0, 4'b1111, 32'h44556677};
        want[2] = {1'b1, 4'b1111, 32'h8899AABB};
        in_q.push_back({1'b0, 48'h001122334455});
        in_q.push_back({1'b1, 48'h66778899AABB});
        run_stream(3, 100, 50);
        checks++;
        if (got.size() != 3 || timed_out) begin
            errors++;
            $display("FAIL two_word_count: got %0d beats (timeout=%0b), want 3", got.size(), timed_out);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL two_word_beat%0d: got %h, want %h", i, got[i], want[i]);
            end
        end
        repeat (2) @(posedge clk_wr);
        #1;
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL two_word_tail: got valid=%b cnt=%0d, want valid=0 cnt=2", out_valid, frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] d;
        logic [36:0] want;
        int          bad_data = 0;
        int          bad_cyc = 0;
        int          bad_rdy = 0;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 6; k++) d[47-8*k -: 8] = 8'(6*w + k);
            in_q.push_back({w == 7, d});
        end
        run_stream(12, 100, 100);
        checks++;
        if (got.size() != 12 || timed_out) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats (timeout=%0b), want 12", got.size(), timed_out);
        end
        for (int k = 0; k < got.size(); k++) begin
            want = {k == 11, 4'b1111, 8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            if (got[k] !== want) begin
                bad_data++;
                if (bad_data <= 3) $display("FAIL b2b_beat%0d: got %h, want %h", k, got[k], want);
            end
            if (got_cyc[k] != k + 1) bad_cyc++;
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL b2b_data: got %0d bad beats, want 0", bad_data);
        end
        checks++;
        if (bad_cyc != 0) begin
            errors++;
            $display("FAIL b2b_consecutive: got %0d beats off cycles 1..12, want 0", bad_cyc);
        end
        for (int i = 0; i < rdy_log.size(); i++) if (rdy_log[i] != (i % 3 != 2)) bad_rdy++;
        checks++;
        if (bad_rdy != 0 || rdy_log.size() != 11) begin
            errors++;
            $display("FAIL b2b_in_ready: got %0d bad of %0d samples, want 0 bad of 11", bad_rdy, rdy_log.size());
        end
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL b2b_frame_cnt: got %0d, want 3", frame_cnt);
        end
    endtask

    task automatic test_consecutive_frames();
        logic [36:0] want[7];
        int          bad = 0;
        want[0] = {1'b0, 4'b1111, 32'hA1A2A3A4};
        want[1] = {1'b1, 4'b1100, 32'hA5A60000};
        want[2] = {1'b0, 4'b1111, 32'hB1B2B3B4};
        want[3] = {1'b1, 4'b1100, 32'hB5B60000};
        want[4] = {1'b0, 4'b1111, 32'hC1C2C3C4};
        want[5] = {1'b0, 4'b1111, 32'hC5C6D1D2};
        want[6] = {1'b1, 4'b1111, 32'hD3D4D5D6};
        in_q.push_back({1'b1, 48'hA1A2A3A4A5A6});
        in_q.push_back({1'b1, 48'hB1B2B3B4B5B6});
        in_q.push_back({1'b0, 48'hC1C2C3C4C5C6});
        in_q.push_back({1'b1, 48'hD1D2D3D4D5D6});
        run_stream(7, 100, 60);
        checks++;
        if (got.size() != 7 || timed_out) begin
            errors++;
            $display("FAIL consec_count: got %0d beats (timeout=%0b), want 7", got.size(), timed_out);
        end
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== want[i] || got_cyc[i] != i + 1) begin
                bad++;
                $display("FAIL consec_beat%0d: got %h at cycle %0d, want %h at cycle %0d", i, got[i], got_cyc[i], want[i], i + 1);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (frame_cnt !== 16'd6) begin
            errors++;
            $display("FAIL consec_frame_cnt: got %0d, want 6", frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h123456789ABC;
        in_last   = 1'b0;
        @(posedge clk_wr);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 32'h12345678) begin
            errors++;
            $display("FAIL async_reset_preload: got valid=%b busy=%b data=%h, want 1 1 12345678", out_valid, busy, out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, out_keep, out_data, in_ready, busy, frame_cnt} !==
            {1'b0, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL async_reset_values: got valid=%b last=%b keep=%b data=%h rdy=%b busy=%b cnt=%0d, want 0 0 1111 00000000 1 0 0",
                     out_valid, out_last, out_keep, out_data, in_ready, busy, frame_cnt);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_backpressure();
        logic [47:0] d;
        logic [7:0]  b[$];
        int          bad = 0;
        int          nw;
        exp_q.delete();
        for (int f = 0; f < 20; f++) begin
            nw = $urandom_range(1, 5);
            b.delete();
            for (int w = 0; w < nw; w++) begin
                d[47:16] = $urandom();
                d[15:0]  = 16'($urandom());
                in_q.push_back({w == nw - 1, d});
                for (int k = 0; k < 6; k++) b.push_back(d[47-8*k -: 8]);
            end
            for (int i = 0; i < b.size(); i += 4) begin
                if (b.size() - i >= 4)
                    exp_q.push_back({i + 4 >= b.size(), 4'b1111, b[i], b[i+1], b[i+2], b[i+3]});
                else
                    exp_q.push_back({1'b1, 4'b1100, b[i], b[i+1], PAD, PAD});
            end
        end
        run_stream(exp_q.size(), 50, 5000);
        checks++;
        if (got.size() != exp_q.size() || timed_out) begin
            errors++;
            $display("FAIL bp_count: got %0d beats (timeout=%0b), want %0d", got.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                bad++;
                if (bad <= 3) $display("FAIL bp_beat%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_data: got %0d bad beats, want 0", bad);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stall_stable: got %0d unstable stalls, want 0", stall_err);
        end
        checks++;
        if (frame_cnt !== 16'd20) begin
            errors++;
            $display("FAIL bp_frame_cnt: got %0d, want 20", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int stray = 0;
        in_q.push_back({1'b0, 48'hDEADBEEFCAFE});
        run_stream(0, 100, 20);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk_wr);
        #1;
        in_q.push_back({1'b1, 48'h010203040506});
        run_stream(2, 100, 50);
        checks++;
        if (got.size() != 2 || timed_out) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d beats (timeout=%0b), want 2", got.size(), timed_out);
        end
        checks++;
        if (got[0] !== {1'b0, 4'b1111, 32'h01020304} || got[1] !== {1'b1, 4'b1100, 32'h05060000}) begin
            errors++;
            $display("FAIL mid_reset_beats: got %h %h, want %h %h", got[0], got[1],
                     {1'b0, 4'b1111, 32'h01020304}, {1'b1, 4'b1100, 32'h05060000});
        end
        repeat (5) begin
            @(negedge clk_wr);
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %0d stray valid cycles busy=%b, want 0 and 0", stray, busy);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_reset_frame_cnt: got %0d, want 1", frame_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_word();
        test_two_word();
        test_back_to_back();
        test_consecutive_frames();
        test_async_reset();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
